mc_controller_ws: RTL and testbench
===================================

// Module: mc_controller_ws
// PURPOSE
//  Multicycle MIPS control FSM, successor to the fixed-latency CORE controller. It adds a
//  memory ready handshake with a configurable timeout, plus BNE/ADDI/ORI support.
//  It sits in the CPU core between the instruction register opcode and the datapath controls.
//  It receives op/zero from the datapath and funct decoding stays in the ALU control block.
// PARAMETERS
//  WAIT_W     4    width of memory wait-state counter
//  MAX_WAIT   15   cycles a request may stay unacknowledged before fault (<= 2**WAIT_W-1)
//  EN_EXT_OPS 1    1: decode BNE/ADDI/ORI; 0: treat them as illegal
// PORTS
//  clk          in   1  clock, rising edge
//  rst          in   1  synchronous reset, active-high
//  op_i         in   6  opcode, inst[31:26]
//  zero_i       in   1  ALU zero flag
//  memready_i   in   1  memory ack; completes the current memread_o/memwrite_o request
//  memread_o    out  1  memory read request (held until ack)
//  memwrite_o   out  1  memory write request (held until ack)
//  alusrca_o    out  1  0:PC 1:regA
//  alusrcb_o    out  3  000:B 001:4 010:sext(imm) 011:sext(imm)<<2 100:zext(imm)
//  aluop_o      out  2  00:add 01:sub 10:funct 11:or
//  pcsource_o   out  2  00:ALU result 01:ALUOut 10:jump target
//  memtoreg_o, iord_o, regdst_o, regwrite_o, irwrite_o, pcen_o  out 1 each  datapath controls
//  illegal_o    out  1  one-cycle pulse on undecodable opcode
//  fault_o      out  1  sticky: memory timeout; cleared only by rst
// BEHAVIOUR
//  Reset: state=FETCH, wait counter=0; all outputs 0 during the rst cycle.
//  FETCH also drives memread, iord=0, alusrca=0, alusrcb=001, aluop=00 and pcsource=00.
//  States and transitions (one state per cycle unless waiting):
//   FETCH   memread=1. If memready_i: irwrite=1, pcen=1, go DECODE. Otherwise hold with irwrite=pcen=0.
//   DECODE  alusrcb=011, aluop=00 (branch target to ALUOut). Decode op:
//           000000 R->RTEX; 100011 lw, 101011 sw->MEMADR; 000100 beq, 000101 bne->BR;
//           000010 j->JMP; 001000 addi->IEX; 001101 ori->IEX; other->ILL.
//           With EN_EXT_OPS=0, bne/addi/ori also go to ILL.
//   MEMADR  alusrca=1, alusrcb=010, aluop=00. Then lw->MEMRD, sw->MEMWR.
//   MEMRD   memread=1, iord=1. memready_i->MEMWB; else hold.
//   MEMWB   regwrite=1, memtoreg=1, regdst=0 ->FETCH.
//   MEMWR   memwrite=1, iord=1. memready_i->FETCH; else hold.
//   RTEX    alusrca=1, alusrcb=000, aluop=10 ->RTWB.
//   RTWB    regwrite=1, regdst=1, memtoreg=0 ->FETCH.
//   BR      alusrca=1, alusrcb=000, aluop=01, pcsource=01 ->FETCH.
//           pcen=zero_i for beq and pcen=~zero_i for bne (combinational, this cycle only).
//   JMP     pcsource=10, pcen=1 ->FETCH.
//   IEX     alusrca=1, aluop=00 with alusrcb=010 (addi), or aluop=11 with alusrcb=100 (ori) ->IWB.
//   IWB     regwrite=1, regdst=0, memtoreg=0 ->FETCH.
//   ILL     illegal_o=1 for exactly one cycle, no writes ->FETCH.
//   FAULT   all strobes 0, fault_o=1; stays until rst.
//  Opcode is latched into an internal register in DECODE. Later states use the latched copy,
//  not op_i.
//  Wait counter: cleared on entry to FETCH, MEMRD or MEMWR and incremented each unacked cycle
//  in those states. When it reaches MAX_WAIT with memready_i=0, go to FAULT next cycle.
//  Ack on the same cycle the counter reaches MAX_WAIT wins; no fault is raised.
//  Zero-wait memory (memready_i tied 1) gives CORE-compatible cycle counts:
//  lw 5, sw 4, R 4, beq/bne 3, j 3, addi/ori 4.
//  memready_i is ignored outside FETCH, MEMRD and MEMWR.
//  rst mid-request drops memread_o/memwrite_o in the rst cycle and restarts at FETCH.
// TESTING
//  T1 rst=1 for 2 cycles -> all outputs 0; first cycle after release: memread_o=1, iord_o=0.
//  T2 zero-wait lw (op 100011) -> state sequence FETCH,DECODE,MEMADR,MEMRD,MEMWB.
//     regwrite_o=1 with memtoreg_o=1 in cycle 5.
//  T3 sw, ready delayed 3 cycles in MEMWR -> memwrite_o high 4 cycles, then FETCH; fault_o=0.
//  T4 bne, zero_i=0 -> pcen_o=1, pcsource_o=01 in BR.
//     Same with zero_i=1 -> pcen_o=0; beq gives the inverse.
//  T5 opcode 111111 -> illegal_o pulses 1 cycle in cycle 3, regwrite/memwrite never assert,
//     back to FETCH.
//  T6 memready_i=0 forever in FETCH, MAX_WAIT=15 -> fault_o rises after 16 cycles and stays.
//     The next rst clears it.

Source files
------------

// File: rtl/mc_controller_ws.sv
// Multicycle MIPS control FSM with memory ready handshake, wait-state timeout
// and optional BNE/ADDI/ORI decode.
module mc_controller_ws #(
  parameter int unsigned WAIT_W     = 4,
  parameter int unsigned MAX_WAIT   = 15,
  parameter bit          EN_EXT_OPS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op_i,
  input  logic       zero_i,
  input  logic       memready_i,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       alusrca_o,
  output logic [2:0] alusrcb_o,
  output logic [1:0] aluop_o,
  output logic [1:0] pcsource_o,
  output logic       memtoreg_o,
  output logic       iord_o,
  output logic       regdst_o,
  output logic       regwrite_o,
  output logic       irwrite_o,
  output logic       pcen_o,
  output logic       illegal_o,
  output logic       fault_o
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_RTEX,
    S_RTWB, S_BR, S_JMP, S_IEX, S_IWB, S_ILL, S_FAULT
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              timeout_c;

  assign timeout_c = (cnt_q == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and datapath controls; controls are forced low while rst is high.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = '0;
    memread_o  = 1'b0;
    memwrite_o = 1'b0;
    alusrca_o  = 1'b0;
    alusrcb_o  = 3'b000;
    aluop_o    = 2'b00;
    pcsource_o = 2'b00;
    memtoreg_o = 1'b0;
    iord_o     = 1'b0;
    regdst_o   = 1'b0;
    regwrite_o = 1'b0;
    irwrite_o  = 1'b0;
    pcen_o     = 1'b0;
    illegal_o  = 1'b0;
    fault_o    = 1'b0;

    case (state_q)
      S_FETCH: begin
        memread_o = 1'b1;
        alusrcb_o = 3'b001;
        if (memready_i) begin
          irwrite_o = 1'b1;
          pcen_o    = 1'b1;
          state_d   = S_DECODE;
        end else if (timeout_c) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        alusrcb_o = 3'b011;
        op_d      = op_i;
        case (op_i)
          OP_R:            state_d = S_RTEX;
          OP_LW, OP_SW:    state_d = S_MEMADR;
          OP_BEQ:          state_d = S_BR;
          OP_J:            state_d = S_JMP;
          OP_BNE:          state_d = EN_EXT_OPS ? S_BR : S_ILL;
          OP_ADDI, OP_ORI: state_d = EN_EXT_OPS ? S_IEX : S_ILL;
          default:         state_d = S_ILL;
        endcase
      end
      S_MEMADR: begin
        alusrca_o = 1'b1;
        alusrcb_o = 3'b010;
        state_d   = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        memread_o = 1'b1;
        iord_o    = 1'b1;
        if (memready_i)     state_d = S_MEMWB;
        else if (timeout_c) state_d = S_FAULT;
      end
      S_MEMWB: begin
        regwrite_o = 1'b1;
        memtoreg_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        memwrite_o = 1'b1;
        iord_o     = 1'b1;
        if (memready_i)     state_d = S_FETCH;
        else if (timeout_c) state_d = S_FAULT;
      end
      S_RTEX: begin
        alusrca_o = 1'b1;
        aluop_o   = 2'b10;
        state_d   = S_RTWB;
      end
      S_RTWB: begin
        regwrite_o = 1'b1;
        regdst_o   = 1'b1;
        state_d    = S_FETCH;
      end
      S_BR: begin
        alusrca_o  = 1'b1;
        aluop_o    = 2'b01;
        pcsource_o = 2'b01;
        pcen_o     = (op_q == OP_BNE) ? ~zero_i : zero_i;
        state_d    = S_FETCH;
      end
      S_JMP: begin
        pcsource_o = 2'b10;
        pcen_o     = 1'b1;
        state_d    = S_FETCH;
      end
      S_IEX: begin
        alusrca_o = 1'b1;
        if (op_q == OP_ORI) begin
          alusrcb_o = 3'b100;
          aluop_o   = 2'b11;
        end else begin
          alusrcb_o = 3'b010;
        end
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite_o = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILL: begin
        illegal_o = 1'b1;
        state_d   = S_FETCH;
      end
      S_FAULT: fault_o = 1'b1;
      default: state_d = S_FETCH;
    endcase

    // Wait counter only advances while a request is held unacknowledged.
    if ((state_d == state_q) &&
        ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR)))
      cnt_d = cnt_q + WAIT_W'(1);

    if (rst) begin
      memread_o  = 1'b0;
      memwrite_o = 1'b0;
      alusrca_o  = 1'b0;
      alusrcb_o  = 3'b000;
      aluop_o    = 2'b00;
      pcsource_o = 2'b00;
      memtoreg_o = 1'b0;
      iord_o     = 1'b0;
      regdst_o   = 1'b0;
      regwrite_o = 1'b0;
      irwrite_o  = 1'b0;
      pcen_o     = 1'b0;
      illegal_o  = 1'b0;
      fault_o    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_controller_ws.sv
// Bench for mc_controller_ws: instruction-level model of the expected control
// word per cycle, compared against the DUT every cycle, plus literal checks.
module tb_mc_controller_ws;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op_i = 6'd0;
  logic       zero_i = 1'b0;
  logic       memready_i = 1'b0;
  logic       memread_o, memwrite_o, alusrca_o;
  logic [2:0] alusrcb_o;
  logic [1:0] aluop_o, pcsource_o;
  logic       memtoreg_o, iord_o, regdst_o, regwrite_o, irwrite_o, pcen_o;
  logic       illegal_o, fault_o;

  int tests = 0;
  int fails = 0;
  int mw_seen = 0;
  int ill_seen = 0;
  int rw_seen = 0;

  mc_controller_ws #(.WAIT_W(4), .MAX_WAIT(15), .EN_EXT_OPS(1'b1)) dut (
    .clk(clk), .rst(rst), .op_i(op_i), .zero_i(zero_i), .memready_i(memready_i),
    .memread_o(memread_o), .memwrite_o(memwrite_o), .alusrca_o(alusrca_o),
    .alusrcb_o(alusrcb_o), .aluop_o(aluop_o), .pcsource_o(pcsource_o),
    .memtoreg_o(memtoreg_o), .iord_o(iord_o), .regdst_o(regdst_o),
    .regwrite_o(regwrite_o), .irwrite_o(irwrite_o), .pcen_o(pcen_o),
    .illegal_o(illegal_o), .fault_o(fault_o)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_J = 6'h02, OP_ADDI = 6'h08, OP_ORI = 6'h0d;
  localparam logic [5:0] JUNK = 6'h3f;

  // Word layout: memread, memwrite, alusrca, alusrcb[3], aluop[2], pcsource[2],
  // then memtoreg, iord, regdst, regwrite, irwrite, pcen, illegal, fault.
  localparam logic [17:0] W_ZERO = 18'd0;
  localparam logic [17:0] F_WAIT = {1'b1, 1'b0, 1'b0, 3'b001, 2'b00, 2'b00, 8'b0000_0000};
  localparam logic [17:0] F_ACK  = {1'b1, 1'b0, 1'b0, 3'b001, 2'b00, 2'b00, 8'b0000_1100};
  localparam logic [17:0] DEC    = {1'b0, 1'b0, 1'b0, 3'b011, 2'b00, 2'b00, 8'b0000_0000};
  localparam logic [17:0] MADR   = {1'b0, 1'b0, 1'b1, 3'b010, 2'b00, 2'b00, 8'b0000_0000};
  localparam logic [17:0] MRD    = {1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 8'b0100_0000};
  localparam logic [17:0] MWB    = {1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 8'b1001_0000};
  localparam logic [17:0] MWR    = {1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 2'b00, 8'b0100_0000};
  localparam logic [17:0] RTEX   = {1'b0, 1'b0, 1'b1, 3'b000, 2'b10, 2'b00, 8'b0000_0000};
  localparam logic [17:0] RTWB   = {1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 8'b0011_0000};
  localparam logic [17:0] BR_NT  = {1'b0, 1'b0, 1'b1, 3'b000, 2'b01, 2'b01, 8'b0000_0000};
  localparam logic [17:0] BR_T   = {1'b0, 1'b0, 1'b1, 3'b000, 2'b01, 2'b01, 8'b0000_0100};
  localparam logic [17:0] JMP    = {1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b10, 8'b0000_0100};
  localparam logic [17:0] IEX_A  = {1'b0, 1'b0, 1'b1, 3'b010, 2'b00, 2'b00, 8'b0000_0000};
  localparam logic [17:0] IEX_O  = {1'b0, 1'b0, 1'b1, 3'b100, 2'b11, 2'b00, 8'b0000_0000};
  localparam logic [17:0] IWB    = {1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 8'b0001_0000};
  localparam logic [17:0] ILL    = {1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 8'b0000_0010};
  localparam logic [17:0] FLT    = {1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00, 8'b0000_0001};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the edge, compare the control word mid-cycle.
  task automatic cyc(input logic r, input logic rdy, input logic [5:0] op, input logic zr,
                     input logic [17:0] e, input string nm);
    logic [17:0] act;
    @(posedge clk);
    #1;
    rst = r;
    memready_i = rdy;
    op_i = op;
    zero_i = zr;
    @(negedge clk);
    act = {memread_o, memwrite_o, alusrca_o, alusrcb_o, aluop_o, pcsource_o,
           memtoreg_o, iord_o, regdst_o, regwrite_o, irwrite_o, pcen_o, illegal_o, fault_o};
    check(nm, 32'(act), 32'(e));
    if (memwrite_o) mw_seen++;
    if (illegal_o)  ill_seen++;
    if (regwrite_o) rw_seen++;
  endtask

  // Memory-request state held for `w` unacked cycles, then acknowledged.
  task automatic mem_wait(input logic [17:0] e, input int w, input string nm, inout int n);
    for (int i = 0; i < w; i++) cyc(1'b0, 1'b0, JUNK, 1'b0, e, nm);
    cyc(1'b0, 1'b1, JUNK, 1'b0, e, nm);
    n += w + 1;
  endtask

  // Whole instruction from FETCH back to FETCH; op_i is garbage outside DECODE.
  task automatic instr(input logic [5:0] op, input logic zr, input int fw, input int mw,
                       output int n);
    logic taken;
    n = 0;
    for (int i = 0; i < fw; i++) begin
      cyc(1'b0, 1'b0, JUNK, zr, F_WAIT, "fetch_wait");
      n++;
    end
    cyc(1'b0, 1'b1, JUNK, zr, F_ACK, "fetch_ack");
    cyc(1'b0, 1'($urandom_range(0, 1)), op, zr, DEC, "decode");
    n += 2;
    case (op)
      OP_LW: begin
        cyc(1'b0, 1'b1, JUNK, zr, MADR, "memadr");
        mem_wait(MRD, mw, "memrd", n);
        cyc(1'b0, 1'b1, JUNK, zr, MWB, "memwb");
        n += 2;
      end
      OP_SW: begin
        cyc(1'b0, 1'b1, JUNK, zr, MADR, "memadr");
        mem_wait(MWR, mw, "memwr", n);
        n += 1;
      end
      OP_R: begin
        cyc(1'b0, 1'b1, JUNK, zr, RTEX, "rtex");
        cyc(1'b0, 1'b1, JUNK, zr, RTWB, "rtwb");
        n += 2;
      end
      OP_BEQ, OP_BNE: begin
        taken = (op == OP_BNE) ? !zr : zr;
        cyc(1'b0, 1'b1, JUNK, zr, taken ? BR_T : BR_NT, "branch");
        n += 1;
      end
      OP_J: begin
        cyc(1'b0, 1'b1, JUNK, zr, JMP, "jump");
        n += 1;
      end
      OP_ADDI, OP_ORI: begin
        cyc(1'b0, 1'b1, JUNK, zr, (op == OP_ORI) ? IEX_O : IEX_A, "iex");
        cyc(1'b0, 1'b1, JUNK, zr, IWB, "iwb");
        n += 2;
      end
      default: begin
        cyc(1'b0, 1'b1, JUNK, zr, ILL, "illegal");
        n += 1;
      end
    endcase
  endtask

  initial begin
    int n;
    int first;

    cyc(1'b1, 1'b1, 6'd0, 1'b0, W_ZERO, "reset");
    cyc(1'b1, 1'b1, 6'd0, 1'b0, W_ZERO, "reset");

    instr(OP_LW, 1'b0, 0, 0, n);   check("lw_cycles", 32'(n), 32'd5);
    mw_seen = 0;
    instr(OP_SW, 1'b0, 0, 3, n);   check("sw_wait_cycles", 32'(n), 32'd7);
    check("sw_memwrite_high", 32'(mw_seen), 32'd4);
    instr(OP_SW, 1'b1, 0, 0, n);   check("sw_cycles", 32'(n), 32'd4);
    instr(OP_R, 1'b0, 0, 0, n);    check("r_cycles", 32'(n), 32'd4);
    instr(OP_BNE, 1'b0, 0, 0, n);  check("bne_cycles", 32'(n), 32'd3);
    instr(OP_BNE, 1'b1, 0, 0, n);
    instr(OP_BEQ, 1'b0, 0, 0, n);
    instr(OP_BEQ, 1'b1, 0, 0, n);  check("beq_cycles", 32'(n), 32'd3);
    instr(OP_J, 1'b0, 0, 0, n);    check("j_cycles", 32'(n), 32'd3);
    instr(OP_ADDI, 1'b0, 0, 0, n); check("addi_cycles", 32'(n), 32'd4);
    instr(OP_ORI, 1'b1, 0, 0, n);  check("ori_cycles", 32'(n), 32'd4);

    ill_seen = 0; rw_seen = 0; mw_seen = 0;
    instr(6'h3f, 1'b0, 0, 0, n);   check("ill_cycles", 32'(n), 32'd3);
    check("ill_pulse", 32'(ill_seen), 32'd1);
    check("ill_no_writes", 32'(rw_seen + mw_seen), 32'd0);
    instr(6'h01, 1'b0, 0, 0, n);

    instr(OP_LW, 1'b0, 2, 5, n);   check("lw_waits_cycles", 32'(n), 32'd12);
    instr(OP_LW, 1'b0, 15, 15, n); check("ack_at_max_cycles", 32'(n), 32'd35);
    instr(OP_SW, 1'b0, 0, 15, n);

    // Reset in the middle of an unacked read drops the request.
    cyc(1'b0, 1'b1, JUNK, 1'b0, F_ACK, "fetch_ack");
    cyc(1'b0, 1'b0, OP_LW, 1'b0, DEC, "decode");
    cyc(1'b0, 1'b1, JUNK, 1'b0, MADR, "memadr");
    cyc(1'b0, 1'b0, JUNK, 1'b0, MRD, "memrd");
    cyc(1'b0, 1'b0, JUNK, 1'b0, MRD, "memrd");
    cyc(1'b1, 1'b1, JUNK, 1'b0, W_ZERO, "rst_mid");
    instr(OP_R, 1'b0, 0, 0, n);

    // Fetch never acknowledged: fault after 16 waiting cycles, then sticky.
    first = -1;
    for (int k = 0; k < 24; k++) begin
      cyc(1'b0, (k >= 16) ? 1'($urandom_range(0, 1)) : 1'b0, JUNK, 1'b0,
          (k < 16) ? F_WAIT : FLT, "timeout");
      if (fault_o && first < 0) first = k;
    end
    check("fault_rise_cycle", 32'(first), 32'd16);
    cyc(1'b1, 1'b0, JUNK, 1'b0, W_ZERO, "fault_rst");
    check("fault_cleared", 32'(fault_o), 32'd0);
    instr(OP_ADDI, 1'b0, 0, 0, n);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
